interval_timer_dr: RTL and testbench
====================================

# interval_timer_dr

Loadable down-counting interval timer that is the consumer-side counterpart of the team's loadable up/down DSP counter: instead of producing a running value, it counts a programmed period down by a step and emits terminal-count events. Events go to a downstream block over a valid/ready handshake, with a small pending-event counter and a sticky overrun flag. It sits between register-programmed control (period, step, mode) and event-driven logic such as packet pacing or the interrupt aggregation path.

## Interface
- COUNTER_WIDTH, 16, width of period, step and current value
- EVENT_CNT_WIDTH, 4, width of pending-event counter; saturates at 2^EVENT_CNT_WIDTH-1
- clk_i  in  1  single clock, all logic rising-edge
- a_rst_n_i  in  1  reset, asynchronous assert and active-low; all state clears immediately
- enable_i  in  1  1 = count this cycle; 0 = freeze value
- mode_i  in  1  1 = periodic (auto-reload); 0 = one-shot; sampled at each terminal count
- load_enable_i  in  1  load period and restart; priority over enable_i
- load_data_i  in  COUNTER_WIDTH  period value captured on load
- decrement_i  in  COUNTER_WIDTH  step subtracted per enabled cycle
- value_o  out  COUNTER_WIDTH  current remaining count
- busy_o  out  1  1 while state RUN
- event_valid_o  out  1  at least one event pending
- event_ready_i  in  1  downstream accepts one event when valid & ready
- event_count_o  out  EVENT_CNT_WIDTH  number of pending events
- overrun_o  out  1  sticky: terminal count lost because pending counter was saturated
- clear_overrun_i  in  1  clears overrun_o

## Operation
- States: IDLE (after reset), RUN, DONE. Registered period register holds last loaded value.
- Load (any state): period <= load_data_i, value <= load_data_i; next state RUN if load_data_i != 0, else IDLE with value 0. Pending events and overrun unaffected.
- RUN, enable_i=1, decrement_i != 0: if value > decrement_i then value <= value - decrement_i; else terminal count.
- Terminal count: periodic -> value <= period, stay RUN; one-shot -> value <= 0, go DONE. One event generated.
- RUN with enable_i=0 or decrement_i=0: value holds, no event.
- IDLE/DONE: enable_i ignored; only load leaves them.
- Pending counter: +1 on event, -1 on handshake (event_valid_o & event_ready_i), unchanged when both in same cycle. At saturation, event without handshake -> count holds, overrun_o <= 1.
- overrun_o: cleared by clear_overrun_i; set wins over clear in the same cycle.
- Subtraction is unsigned, COUNTER_WIDTH bits; value never wraps below 0 (terminal test uses value <= decrement_i).

## Timing
- Reset values: value_o 0, busy_o 0, event_valid_o 0, event_count_o 0, overrun_o 0; state IDLE; period 0.
- All outputs registered; no combinational input-to-output paths.
- Load at edge N: value_o = load_data_i and busy_o = 1 from N+1.
- Periodic period P, step 1, enable held high: one event every P cycles; first event visible on event_valid_o P cycles after the first enabled cycle.
- Event at edge N: event_count_o increments and event_valid_o rises at N+1.
- Handshake at edge N: event_count_o decrements at N+1; event_valid_o falls at N+1 if count reaches 0.
- Load coincident with terminal condition: load wins, no event generated.
- Reset mid-run: immediate clear, pending events discarded.

## Structure
- Shared header interval_timer_dr_defs.vh: state encodings (IDLE/RUN/DONE), mode constants (PERIODIC=1, ONE_SHOT=0).
- One sub-module: event_pending_counter (saturating up/down counter with valid output and sticky overrun), reusable by other event sources.
- Top holds state machine, period register and subtract/compare datapath.

## Test plan
- Reset then load 5, decrement 1, periodic, enable high, ready high -> value_o 5,4,3,2,1,5,...; event_valid_o one-cycle pulse every 5 cycles; overrun_o 0.
- Load 10, decrement 3, one-shot -> value_o 10,7,4,1,0; busy_o falls with state DONE; exactly one event; further enable produces nothing.
- Load 2, decrement 1, periodic, ready low for 40 cycles, EVENT_CNT_WIDTH 4 -> event_count_o climbs to 15 and holds, overrun_o 1; clear_overrun_i pulse -> 0; ready high drains count to 0.
- Event and handshake in same cycle with count 3 -> count stays 3; load 0 while RUN -> IDLE, value_o 0, busy_o 0, pending count kept.
- Load 8, enable toggled 1/0 each cycle -> terminal count after 16 cycles; load 4 asserted on terminal cycle -> no event, value_o 4.
- Assert a_rst_n_i low mid-run between clock edges -> all outputs 0 immediately, before next edge.

Source files
------------

// File: rtl/interval_timer_dr_pkg.sv
// ============================================================================
// interval_timer_dr_pkg : state encodings and mode constants for the timer
// Revision: 1.0
// ============================================================================
`default_nettype none

package interval_timer_dr_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONE_SHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/interval_timer_dr_if.sv
// ============================================================================
// interval_timer_dr_if : event valid/ready handshake plus pending-event count
// Revision: 1.0
// ============================================================================
`default_nettype none

interface interval_timer_dr_if #(
  parameter int EVENT_CNT_WIDTH = 4
);
  import interval_timer_dr_pkg::*;

  logic                       valid;
  logic                       ready;
  logic [EVENT_CNT_WIDTH-1:0] count;

  modport master (output valid, output count, input ready);
  modport slave  (input valid, input count, output ready);

endinterface

`default_nettype wire

// File: rtl/interval_timer_dr_event_pending_counter.sv
// ============================================================================
// event_pending_counter : saturating pending-event counter, sticky overrun
// Revision: 1.0
// ============================================================================
`default_nettype none

module event_pending_counter
  import interval_timer_dr_pkg::*;
#(
  parameter int CNT_WIDTH = 4
) (
  input  wire logic                 clk_i,
  input  wire logic                 a_rst_n_i,
  input  wire logic                 event_i,
  input  wire logic                 ready_i,
  input  wire logic                 clear_overrun_i,
  output logic                      valid_o,
  output logic [CNT_WIDTH-1:0]      count_o,
  output logic                      overrun_o
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 w_hs;
  logic                 w_drop;

  assign w_hs = (count_q != '0) & ready_i;

  always_comb begin
    count_d = count_q;
    w_drop  = 1'b0;
    if (event_i && !w_hs) begin
      if (count_q == C_MAX) begin
        w_drop = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (!event_i && w_hs) begin
      count_d = count_q - 1'b1;
    end
    // A dropped event in the same cycle as a clear must remain visible
    overrun_d = w_drop | (overrun_q & ~clear_overrun_i);
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/interval_timer_dr.sv
// ============================================================================
// interval_timer_dr : loadable down-counting interval timer emitting events
// Revision: 1.0
// ============================================================================
`default_nettype none

module interval_timer_dr
  import interval_timer_dr_pkg::*;
#(
  parameter int COUNTER_WIDTH   = 16,
  parameter int EVENT_CNT_WIDTH = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     a_rst_n_i,
  input  wire logic                     enable_i,
  input  wire logic                     mode_i,
  input  wire logic                     load_enable_i,
  input  wire logic [COUNTER_WIDTH-1:0] load_data_i,
  input  wire logic [COUNTER_WIDTH-1:0] decrement_i,
  input  wire logic                     clear_overrun_i,
  output logic      [COUNTER_WIDTH-1:0] value_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  interval_timer_dr_if.master           evt
);

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] value_q, value_d;
  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic                     w_event;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    period_d = period_q;
    w_event  = 1'b0;
    if (load_enable_i) begin
      period_d = load_data_i;
      value_d  = load_data_i;
      state_d  = (load_data_i != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && enable_i && decrement_i != '0) begin
      // Terminal on value <= step keeps the count from wrapping below zero
      if (value_q > decrement_i) begin
        value_d = value_q - decrement_i;
      end else begin
        w_event = 1'b1;
        if (mode_i == MODE_PERIODIC) begin
          value_d = period_q;
        end else begin
          value_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q  <= ST_IDLE;
      value_q  <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      period_q <= period_d;
    end
  end

  assign value_o = value_q;
  assign busy_o  = (state_q == ST_RUN);

  event_pending_counter #(
    .CNT_WIDTH (EVENT_CNT_WIDTH)
  ) u_pending (
    .clk_i           (clk_i),
    .a_rst_n_i       (a_rst_n_i),
    .event_i         (w_event),
    .ready_i         (evt.ready),
    .clear_overrun_i (clear_overrun_i),
    .valid_o         (evt.valid),
    .count_o         (evt.count),
    .overrun_o       (overrun_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_dr.sv
// ============================================================================
// tb_interval_timer_dr : vector table with scoreboard plus corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interval_timer_dr;

  localparam int CW = 16;
  localparam int EW = 4;

  typedef struct {
    int ld, data, en, mode, dec, rdy, clr;
    int e_value, e_busy, e_valid, e_cnt, e_ovr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, mode = 1'b0, ld = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [CW-1:0] ld_data = '0, dec = '0;
  logic [CW-1:0] value;
  logic          busy, ovr;

  int passed = 0;
  int total  = 0;

  interval_timer_dr_if #(.EVENT_CNT_WIDTH(EW)) evt ();
  assign evt.ready = rdy;

  interval_timer_dr #(.COUNTER_WIDTH(CW), .EVENT_CNT_WIDTH(EW)) dut (
    .clk_i           (clk),
    .a_rst_n_i       (rst_n),
    .enable_i        (en),
    .mode_i          (mode),
    .load_enable_i   (ld),
    .load_data_i     (ld_data),
    .decrement_i     (dec),
    .clear_overrun_i (clr),
    .value_o         (value),
    .busy_o          (busy),
    .overrun_o       (ovr),
    .evt             (evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input int l, input int d, input int e, input int m,
                       input int s, input int r, input int c);
    ld = l[0]; ld_data = d[CW-1:0]; en = e[0]; mode = m[0];
    dec = s[CW-1:0]; rdy = r[0]; clr = c[0];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int l, int d, int e, int m, int s, int r, int c,
                              int ev, int eb, int evl, int ec, int eo);
    vec_t v;
    v.ld = l; v.data = d; v.en = e; v.mode = m; v.dec = s; v.rdy = r; v.clr = c;
    v.e_value = ev; v.e_busy = eb; v.e_valid = evl; v.e_cnt = ec; v.e_ovr = eo;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;
    int   n;

    // ---- reset state ----
    #12;
    chk("rst.value", int'(value), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(evt.valid), 0);
    chk("rst.count", int'(evt.count), 0);
    chk("rst.ovr", int'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    //            ld data en md dec rdy clr | value busy valid cnt ovr
    // periodic 5, step 1, ready high
    vecs.push_back(mk(1, 5, 0, 1, 1, 1, 0,   5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   5, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   5, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   4, 1, 0, 0, 0));
    // one-shot 10, step 3 (load beats enable)
    vecs.push_back(mk(1, 10, 1, 0, 3, 1, 0,  10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   7, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0,   0, 0, 0, 0, 0));
    // periodic 2, ready low: build up count 3, then event + handshake
    vecs.push_back(mk(1, 2, 0, 1, 1, 0, 0,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   2, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   2, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0,   2, 1, 1, 3, 0));
    // load 0 while running -> idle, pending kept; idle ignores enable
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,   0, 0, 1, 3, 0));
    // zero step holds; value == step is terminal
    vecs.push_back(mk(1, 3, 0, 1, 1, 0, 0,   3, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,   3, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0,   3, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 0,   1, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 0,   0, 0, 1, 5, 0));
    // drain
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].data, vecs[i].en, vecs[i].mode,
            vecs[i].dec, vecs[i].rdy, vecs[i].clr);
      sb.push_back(vecs[i]);
      tick(1);
      e = sb.pop_front();
      chk($sformatf("v%0d.value", i), int'(value), e.e_value);
      chk($sformatf("v%0d.busy", i), int'(busy), e.e_busy);
      chk($sformatf("v%0d.valid", i), int'(evt.valid), e.e_valid);
      chk($sformatf("v%0d.count", i), int'(evt.count), e.e_cnt);
      chk($sformatf("v%0d.ovr", i), int'(ovr), e.e_ovr);
    end

    // ---- saturation and overrun ----
    drive(1, 2, 0, 1, 1, 0, 0);
    tick(1);
    drive(0, 0, 1, 1, 1, 0, 0);
    tick(40);
    chk("sat.count", int'(evt.count), 15);
    chk("sat.ovr", int'(ovr), 1);
    n = 0;
    while (value != 1 && n < 10) begin tick(1); n++; end
    chk("sat.phase_found", int'(n < 10), 1);
    drive(0, 0, 1, 1, 1, 0, 1);
    tick(1);
    chk("ovr.set_wins", int'(ovr), 1);
    chk("ovr.count_hold", int'(evt.count), 15);
    drive(0, 0, 0, 1, 1, 0, 1);
    tick(1);
    chk("ovr.cleared", int'(ovr), 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    tick(1);
    chk("drain.first", int'(evt.count), 14);
    tick(14);
    chk("drain.count", int'(evt.count), 0);
    chk("drain.valid", int'(evt.valid), 0);

    // ---- enable toggling: 8 enabled cycles over 16 ----
    drive(1, 8, 0, 1, 1, 0, 0);
    tick(1);
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, (i % 2 == 0) ? 1 : 0, 1, 1, 0, 0);
      tick(1);
    end
    chk("tog.value14", int'(value), 1);
    chk("tog.count14", int'(evt.count), 0);
    for (int i = 14; i < 16; i++) begin
      drive(0, 0, (i % 2 == 0) ? 1 : 0, 1, 1, 0, 0);
      tick(1);
    end
    chk("tog.value16", int'(value), 8);
    chk("tog.count16", int'(evt.count), 1);

    // ---- load on terminal cycle wins ----
    drive(0, 0, 1, 1, 1, 0, 0);
    n = 0;
    while (value != 1 && n < 20) begin tick(1); n++; end
    chk("ldterm.phase_found", int'(n < 20), 1);
    drive(1, 4, 1, 1, 1, 0, 0);
    tick(1);
    chk("ldterm.value", int'(value), 4);
    chk("ldterm.count", int'(evt.count), 1);
    chk("ldterm.busy", int'(busy), 1);

    // ---- asynchronous reset between edges ----
    drive(0, 0, 1, 1, 1, 0, 0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.value", int'(value), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.valid", int'(evt.valid), 0);
    chk("arst.count", int'(evt.count), 0);
    chk("arst.ovr", int'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("arst.idle_after", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
